// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared defaults, line-offset helper and refill FSM states
package cache_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_WORDS_PER_LINE = 4;

    // Byte-offset bits inside one line: word-index bits plus the 2 byte bits.
    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line) + 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } refill_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count one event this cycle
//   count      : current value, sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - cache miss line-refill controller
// Fetches a whole aligned line word by word from memory and writes it into
// the cache data array, then pulses fill_done so the cache can mark the line
// valid. One memory request outstanding at a time, words in order from 0.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   miss_valid/miss_addr  : refill request from the cache, held until accepted
//   miss_ready            : controller idle, request accepted this edge
//   mem_req/mem_addr      : word read request, held until mem_gnt
//   mem_rvalid/mem_rdata  : read data return
//   fill_we/fill_addr/fill_data : one word written into the line
//   fill_done             : line complete, coincides with the last fill_we
//   miss_cnt              : accepted misses, saturating
//   proto_err             : sticky, read data arrived with nothing outstanding
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_done,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic              proto_err
);

    localparam int OFF_W = off_w(WORDS_PER_LINE);
    localparam int K_W   = OFF_W - 2;
    localparam int HI_W  = ADDR_W - OFF_W;

    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(WORDS_PER_LINE * 4 - 1));
    localparam logic [K_W-1:0]    K_ONE     = K_W'(1);
    localparam logic [K_W-1:0]    K_LAST    = K_W'(WORDS_PER_LINE - 1);

    refill_state_t   state;
    logic [K_W-1:0]  k;
    logic [HI_W-1:0] base_hi;
    logic [K_W-1:0]  k_next;
    logic            accept;

    assign k_next = k + K_ONE;
    assign accept = miss_valid && (state == IDLE);

    // Status outputs decode the state register only, so no input reaches an
    // output combinationally.
    assign miss_ready = (state == IDLE);
    assign mem_req    = (state == REQ);
    assign fill_done  = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            base_hi   <= '0;
            mem_addr  <= '0;
            fill_we   <= 1'b0;
            fill_addr <= '0;
            fill_data <= '0;
            proto_err <= 1'b0;
        end else begin
            fill_we <= 1'b0;

            // Outside WAIT there is no outstanding read, so any data beat is
            // a protocol violation; it is flagged and its data dropped.
            if (mem_rvalid && (state != WAIT)) begin
                proto_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        base_hi  <= miss_addr[ADDR_W-1:OFF_W];
                        mem_addr <= miss_addr & LINE_MASK;
                        k        <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        fill_we   <= 1'b1;
                        fill_data <= mem_rdata;
                        fill_addr <= {base_hi, k, 2'b00};
                        if (k == K_LAST) begin
                            state <= DONE;
                        end else begin
                            // Word index never carries into tag/index bits.
                            k        <= k_next;
                            mem_addr <= {base_hi, k_next, 2'b00};
                            state    <= REQ;
                        end
                    end
                end
                DONE: begin
                    k     <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .count (miss_cnt)
    );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int WPL     = 4;
    localparam int CNT_W   = 4;
    localparam int LINE_B  = WPL * 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              miss_valid = 1'b0;
    logic [ADDR_W-1:0] miss_addr = '0;
    logic              miss_ready;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              fill_done;
    logic [CNT_W-1:0]  miss_cnt;
    logic              proto_err;

    always #5 clk = ~clk;

    cache_refill_ctrl #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .WORDS_PER_LINE (WPL),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .miss_ready (miss_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .fill_we    (fill_we),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .fill_done  (fill_done),
        .miss_cnt   (miss_cnt),
        .proto_err  (proto_err)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_miss = 0;
    logic        exp_perr = 1'b0;
    logic [31:0] salt = 32'h0;

    // Backing memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic int exp_cnt();
        return (n_miss > CNT_MAX) ? CNT_MAX : n_miss;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miss_ready"}, 64'(miss_ready), 64'd1);
        check({tag, "_mem_req"},    64'(mem_req),    64'd0);
        check({tag, "_mem_addr"},   64'(mem_addr),   64'd0);
        check({tag, "_fill_we"},    64'(fill_we),    64'd0);
        check({tag, "_fill_addr"},  64'(fill_addr),  64'd0);
        check({tag, "_fill_data"},  64'(fill_data),  64'd0);
        check({tag, "_fill_done"},  64'(fill_done),  64'd0);
        check({tag, "_miss_cnt"},   64'(miss_cnt),   64'd0);
        check({tag, "_proto_err"},  64'(proto_err),  64'd0);
    endtask

    // One full refill. Called in an IDLE cycle (#1 after an edge).
    // rnd: random gnt/rvalid stalls 0..3; otherwise gnt stalls sl cycles on word sw.
    // pend: keep a second miss (paddr) asserted while this one is busy.
    // abort_word: pull reset in the first WAIT cycle of that word.
    task automatic refill(input logic [31:0] addr, input bit rnd, input int sw, input int sl,
                          input bit pend, input logic [31:0] paddr, input int abort_word);
        logic [31:0] base;
        logic [31:0] wa;
        int          t0;
        int          stalls;
        int          g;
        int          r;
        base = addr & ~32'(LINE_B - 1);
        check("idle_ready", 64'(miss_ready), 64'd1);
        miss_valid = 1'b1;
        miss_addr  = addr;
        tick();
        n_miss++;
        t0     = cyc;
        stalls = 0;
        miss_valid = pend;
        miss_addr  = pend ? paddr : $urandom;
        for (int k = 0; k < WPL; k++) begin
            wa = base + 32'(4 * k);
            g  = rnd ? int'($urandom_range(0, 3)) : ((k == sw) ? sl : 0);
            stalls += g;
            for (int i = 0; i <= g; i++) begin
                check("req", 64'(mem_req), 64'd1);
                check("mem_addr", 64'(mem_addr), 64'(wa));
                check("busy_not_ready", 64'(miss_ready), 64'd0);
                if (i > 0) check("no_dup_we", 64'(fill_we), 64'd0);
                mem_gnt = (i == g);
                tick();
            end
            mem_gnt = 1'b0;
            if (k == abort_word) begin
                miss_valid = 1'b0;
                rst_n = 1'b0;
                #2;
                check_reset_outputs("async_rst");
                tick();
                tick();
                check_reset_outputs("held_rst");
                rst_n    = 1'b1;
                n_miss   = 0;
                exp_perr = 1'b0;
                return;
            end
            r = rnd ? int'($urandom_range(0, 3)) : 0;
            stalls += r;
            for (int j = 0; j <= r; j++) begin
                check("wait_no_req", 64'(mem_req), 64'd0);
                check("wait_no_we", 64'(fill_we), 64'd0);
                mem_rvalid = (j == r);
                mem_rdata  = (j == r) ? mem_fn(wa) : $urandom;
                tick();
            end
            mem_rvalid = 1'b0;
            check("fill_we", 64'(fill_we), 64'd1);
            check("fill_addr", 64'(fill_addr), 64'(wa));
            check("fill_data", 64'(fill_data), 64'(mem_fn(wa)));
            check("fill_done", 64'(fill_done), 64'(k == WPL - 1));
        end
        check("done_cycle", 64'(cyc - t0 + 1), 64'(2 * WPL + 1 + stalls));
        check("miss_cnt", 64'(miss_cnt), 64'(exp_cnt()));
        check("proto_err", 64'(proto_err), 64'(exp_perr));
        tick();
        check("ready_after", 64'(miss_ready), 64'd1);
        check("quiet_we", 64'(fill_we), 64'd0);
        check("single_done", 64'(fill_done), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        salt = $urandom;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Zero-wait refill of 0x1234: words 0x1230..0x123C, fill_done in cycle 9.
        refill(32'h0000_1234, 1'b0, -1, 0, 1'b0, 32'h0, -1);

        // Grant withheld 3 cycles on word 1.
        refill($urandom, 1'b0, 1, 3, 1'b0, 32'h0, -1);

        // Second miss at 0x40 held during a refill, accepted at the next IDLE.
        refill($urandom, 1'b1, -1, 0, 1'b1, 32'h0000_0040, -1);
        refill(32'h0000_0040, 1'b1, -1, 0, 1'b0, 32'h0, -1);

        // Reset during WAIT of word 2, then a fresh refill from word 0.
        refill($urandom, 1'b0, -1, 0, 1'b0, 32'h0, 2);
        refill($urandom, 1'b1, -1, 0, 1'b0, 32'h0, -1);

        // Stray read data in IDLE.
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        tick();
        mem_rvalid = 1'b0;
        exp_perr   = 1'b1;
        check("stray_no_we", 64'(fill_we), 64'd0);
        check("stray_perr", 64'(proto_err), 64'd1);
        tick();
        tick();
        check("perr_sticky", 64'(proto_err), 64'd1);

        // Enough random refills to drive the 4-bit counter into saturation.
        for (int n = 0; n < 18; n++) begin
            refill($urandom, 1'b1, -1, 0, 1'b0, 32'h0, -1);
        end
        check("cnt_saturated", 64'(miss_cnt), 64'(CNT_MAX));

        rst_n = 1'b0;
        #2;
        check_reset_outputs("final_rst");
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-refill controller sitting directly downstream of the direct-mapped cache `main`. When the cache reports a miss it fetches the full aligned line from backing memory one word at a time and streams the words into the cache data array. It then signals line completion so the cache can set tag/valid. It also keeps a saturating miss counter for performance checking.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, memory/cache word width
- `WORDS_PER_LINE`, 4, words per cache line; power of two, ≥2
- `CNT_W`, 16, miss-counter width

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `miss_valid` in 1: cache requests a refill; held until accepted
- `miss_addr` in ADDR_W: faulting byte address
- `miss_ready` out 1: controller idle and accepting
- `mem_req` out 1: read request to memory
- `mem_addr` out ADDR_W: word-aligned request address
- `mem_gnt` in 1: memory accepts the request this cycle
- `mem_rvalid` in 1: read data valid
- `mem_rdata` in DATA_W: read data
- `fill_we` out 1: write one word into the cache line
- `fill_addr` out ADDR_W: byte address of the word being written
- `fill_data` out DATA_W: word being written
- `fill_done` out 1: one-cycle pulse; line complete
- `miss_cnt` out CNT_W: accepted misses, saturating
- `proto_err` out 1: sticky; `mem_rvalid` arrived outside WAIT

## Operation
- OFF_W = log2(WORDS_PER_LINE)+2. Line base = `miss_addr` with the low OFF_W bits cleared. It is latched at acceptance.
- Word k address = {base[ADDR_W-1:OFF_W], k[OFF_W-3:0], 2'b00}. There is no carry into tag or index bits. Words are fetched in order from k=0; no critical-word-first.
- Handshake: a miss is accepted on an edge where `miss_valid && miss_ready`.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: `miss_ready`=1. On acceptance, go to REQ, set k=0, and increment `miss_cnt`.
  - REQ: `mem_req`=1, `mem_addr`=word k. Stay until `mem_gnt`, then go to WAIT. `mem_addr` is stable while `mem_req` is high.
  - WAIT: hold until `mem_rvalid`. On `mem_rvalid`, register `mem_rdata` and word k's address into the fill registers and pulse `fill_we` next cycle. If k is the last word, go to DONE; otherwise go to REQ with k+1.
  - DONE: `fill_done`=1 for exactly one cycle, coinciding with the last `fill_we`. Then go to IDLE and wrap k to 0.
- Only one memory request is outstanding at a time.
- `mem_rvalid` in IDLE, REQ or DONE is ignored for data and sets `proto_err`. Only reset clears `proto_err`.
- `miss_valid` while busy: `miss_ready`=0; the request stays pending and is accepted in the first IDLE cycle.
- `miss_cnt` saturates at all-ones and never wraps.

## Timing
- Reset values: state IDLE, k=0, `miss_ready`=1. All of these are 0: `mem_req`, `mem_addr`, `fill_we`, `fill_addr`, `fill_data`, `fill_done`, `miss_cnt`, `proto_err`.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- Zero-wait memory (`mem_gnt` in first REQ cycle, `mem_rvalid` in first WAIT cycle), acceptance at edge 0:
  - REQ w0 in cycle 1, WAIT in cycle 2.
  - `fill_we` for w0 in cycle 3, alongside REQ for w1.
  - For WORDS_PER_LINE=4: last `fill_we` plus `fill_done` in cycle 9; `miss_ready`=1 in cycle 10.
  - General form: 2·WORDS_PER_LINE+1 cycles from acceptance to `fill_done`.
- Each gnt or rvalid stall adds one cycle per stalled cycle.
- Reset mid-refill: immediate return to IDLE. There is no `fill_done` for the partial line; the cache keeps that line invalid.

## Structure
- Shared package `cache_pkg`:
  - defaults for ADDR_W, DATA_W, WORDS_PER_LINE
  - OFF_W function
  - state enum `refill_state_t`
- One natural sub-module: `sat_counter` (parameterised width, enable, async active-low reset) for `miss_cnt`.
- The FSM and the fill registers stay in the top block.

## Test plan
- Zero-wait refill, `miss_addr`=0x0000_1234: `mem_addr` sequence 0x1230, 0x1234, 0x1238, 0x123C. `fill_data` matches memory, `fill_done` in cycle 9, `miss_cnt`=1.
- `mem_gnt` withheld 3 cycles on word 1: `mem_addr`=0x…4 held stable, `fill_done` lands 3 cycles later, no duplicate `fill_we`.
- Second `miss_valid` (addr 0x40) asserted mid-refill: `miss_ready`=0 until the first refill's IDLE, then accepted. Fills 0x40–0x4C, `miss_cnt`=2.
- `rst_n` low during WAIT of word 2: all outputs return to reset values asynchronously and no `fill_done` is seen. After release a new miss refills from word 0.
- `mem_rvalid` pulsed in IDLE: no `fill_we`, `proto_err`=1 and stays 1 until reset.
- CNT_W=4, 17 misses: `miss_cnt` sticks at 0xF.
